// File: rtl/axil_initiator.sv
// axil_initiator
// ----------------------------------------------------------------------------
// Bridges a single-beat valid/ready register command port onto an AXI4-Lite
// initiator port (m_ctrl_*), and returns each outcome on a response port.
// Only one transaction is in flight at a time.
//
// Optional feature macro: AXIL_INIT_TIMEOUT_EN
//   Defined     : a watchdog bounds the wait in WRESP/RDATA. When it expires,
//                 the block returns a synthesized SLVERR response with
//                 rsp_timeout = 1. The late B/R beat is drained and discarded
//                 before the next command is accepted.
//   Not defined : WRESP/RDATA wait indefinitely and rsp_timeout is tied to 0.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   cmd_*                       command in (valid/ready, write, addr, wdata,
//                               wstrb, prot)
//   rsp_*                       response out (valid/ready, write, rdata,
//                               resp, timeout)
//   m_ctrl_aw*/w*/b*/ar*/r*     AXI4-Lite initiator channels
// ----------------------------------------------------------------------------
module axil_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  input  logic [2:0]          cmd_prot,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // AXI4-Lite write address
  output logic                m_ctrl_awvalid,
  input  logic                m_ctrl_awready,
  output logic [ADDR_W-1:0]   m_ctrl_awaddr,
  output logic [2:0]          m_ctrl_awprot,
  // AXI4-Lite write data
  output logic                m_ctrl_wvalid,
  input  logic                m_ctrl_wready,
  output logic [DATA_W-1:0]   m_ctrl_wdata,
  output logic [DATA_W/8-1:0] m_ctrl_wstrb,
  // AXI4-Lite write response
  input  logic                m_ctrl_bvalid,
  output logic                m_ctrl_bready,
  input  logic [1:0]          m_ctrl_bresp,
  // AXI4-Lite read address
  output logic                m_ctrl_arvalid,
  input  logic                m_ctrl_arready,
  output logic [ADDR_W-1:0]   m_ctrl_araddr,
  output logic [2:0]          m_ctrl_arprot,
  // AXI4-Lite read data
  input  logic                m_ctrl_rvalid,
  output logic                m_ctrl_rready,
  input  logic [DATA_W-1:0]   m_ctrl_rdata,
  input  logic [1:0]          m_ctrl_rresp
);

  localparam int STRB_W = DATA_W / 8;

  // An illegally parameterised instance never accepts a command, so a bad
  // configuration shows up as a stalled command port instead of corrupt beats.
  localparam bit CFG_OK = ((DATA_W == 32) || (DATA_W == 64)) && (TIMEOUT >= 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t state_reg, state_next;

  // request-side registers
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        prot_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] wstrb_reg;
  logic              awvalid_reg;
  logic              wvalid_reg;
  logic              arvalid_reg;
  logic              aw_done_reg;
  logic              w_done_reg;

  // response-side registers
  logic              rsp_write_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic [1:0]        rsp_resp_reg;

  // handshakes
  logic cmd_fire;
  logic aw_fire;
  logic w_fire;
  logic ar_fire;
  logic aw_ok;
  logic w_ok;
  logic b_take;
  logic r_take;

  // watchdog interface (constant in the default build)
  logic wd_expire;
  logic drain_any;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = awvalid_reg && m_ctrl_awready;
  assign w_fire   = wvalid_reg && m_ctrl_wready;
  assign ar_fire  = arvalid_reg && m_ctrl_arready;
  // a channel counts as done if it completed earlier or completes this cycle
  assign aw_ok    = aw_done_reg || aw_fire;
  assign w_ok     = w_done_reg || w_fire;
  // B/R taken as the real response only in their wait states; beats seen
  // while draining are discarded by the watchdog logic
  assign b_take   = (state_reg == WRESP) && m_ctrl_bvalid;
  assign r_take   = (state_reg == RDATA) && m_ctrl_rvalid;

  assign cmd_ready = CFG_OK && (state_reg == IDLE) && !reset && !drain_any;

`ifdef AXIL_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt_reg;
  logic             bdrain_reg;
  logic             rdrain_reg;
  logic             rsp_timeout_reg;
  logic             waiting;

  assign waiting   = ((state_reg == WRESP) && !m_ctrl_bvalid) ||
                     ((state_reg == RDATA) && !m_ctrl_rvalid);
  // wd_cnt_reg is 0 in the first cycle of the wait state, so it reads
  // TIMEOUT-1 in the TIMEOUT-th cycle spent waiting
  assign wd_expire = waiting && (wd_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign drain_any = bdrain_reg || rdrain_reg;

  assign m_ctrl_bready = (state_reg == WRESP) || bdrain_reg;
  assign m_ctrl_rready = (state_reg == RDATA) || rdrain_reg;
  assign rsp_timeout   = rsp_timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg <= '0;
      bdrain_reg <= 1'b0;
      rdrain_reg <= 1'b0;
    end else begin
      // every entry into WRESP/RDATA comes from another state, so clearing
      // outside them restarts the count on entry
      if ((state_reg == WRESP) || (state_reg == RDATA)) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end else begin
        wd_cnt_reg <= '0;
      end

      // drains cannot overlap a wait state since no command is accepted
      // while a drain is pending
      if (wd_expire && (state_reg == WRESP)) begin
        bdrain_reg <= 1'b1;
      end else if (bdrain_reg && m_ctrl_bvalid) begin
        bdrain_reg <= 1'b0;
      end

      if (wd_expire && (state_reg == RDATA)) begin
        rdrain_reg <= 1'b1;
      end else if (rdrain_reg && m_ctrl_rvalid) begin
        rdrain_reg <= 1'b0;
      end
    end
  end
`else
  assign wd_expire     = 1'b0;
  assign drain_any     = 1'b0;
  assign m_ctrl_bready = (state_reg == WRESP);
  assign m_ctrl_rready = (state_reg == RDATA);
  assign rsp_timeout   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          state_next = cmd_write ? WADDR : RADDR;
        end
      end
      WADDR: begin
        if (aw_ok && w_ok) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        if (b_take || wd_expire) begin
          state_next = RSP;
        end
      end
      RADDR: begin
        if (ar_fire) begin
          state_next = RDATA;
        end
      end
      RDATA: begin
        if (r_take || wd_expire) begin
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request channels and response capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg      <= '0;
      prot_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
`ifdef AXIL_INIT_TIMEOUT_EN
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      if (cmd_fire) begin
        addr_reg    <= cmd_addr;
        prot_reg    <= cmd_prot;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
        if (cmd_write) begin
          wdata_reg   <= cmd_wdata;
          wstrb_reg   <= cmd_wstrb;
          awvalid_reg <= 1'b1;
          wvalid_reg  <= 1'b1;
        end else begin
          arvalid_reg <= 1'b1;
        end
      end

      // each valid drops on its own handshake edge
      if (aw_fire) begin
        awvalid_reg <= 1'b0;
        aw_done_reg <= 1'b1;
      end
      if (w_fire) begin
        wvalid_reg <= 1'b0;
        w_done_reg <= 1'b1;
      end
      if (ar_fire) begin
        arvalid_reg <= 1'b0;
      end

      if (b_take) begin
        rsp_write_reg <= 1'b1;
        rsp_rdata_reg <= '0;
        rsp_resp_reg  <= m_ctrl_bresp;
`ifdef AXIL_INIT_TIMEOUT_EN
        rsp_timeout_reg <= 1'b0;
`endif
      end else if (r_take) begin
        rsp_write_reg <= 1'b0;
        rsp_rdata_reg <= m_ctrl_rdata;
        rsp_resp_reg  <= m_ctrl_rresp;
`ifdef AXIL_INIT_TIMEOUT_EN
        rsp_timeout_reg <= 1'b0;
`endif
      end
`ifdef AXIL_INIT_TIMEOUT_EN
      else if (wd_expire) begin
        rsp_write_reg   <= (state_reg == WRESP);
        rsp_rdata_reg   <= '0;
        rsp_resp_reg    <= 2'b10;
        rsp_timeout_reg <= 1'b1;
      end
`endif
    end
  end

  assign m_ctrl_awvalid = awvalid_reg;
  assign m_ctrl_awaddr  = addr_reg;
  assign m_ctrl_awprot  = prot_reg;
  assign m_ctrl_wvalid  = wvalid_reg;
  assign m_ctrl_wdata   = wdata_reg;
  assign m_ctrl_wstrb   = wstrb_reg;
  assign m_ctrl_arvalid = arvalid_reg;
  assign m_ctrl_araddr  = addr_reg;
  assign m_ctrl_arprot  = prot_reg;

  assign rsp_valid = (state_reg == RSP);
  assign rsp_write = rsp_write_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;

endmodule

// File: tb/tb_axil_initiator.sv
// Testbench for axil_initiator: a scoreboard queue holds the expected
// response of every accepted command; a response monitor pops and compares.
// A small AXI4-Lite target model with per-channel ready/valid delays checks
// the request beats and counts handshakes.
module tb_axil_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          m_ctrl_awvalid, m_ctrl_awready;
  logic [AW-1:0] m_ctrl_awaddr;
  logic [2:0]    m_ctrl_awprot;
  logic          m_ctrl_wvalid, m_ctrl_wready;
  logic [DW-1:0] m_ctrl_wdata;
  logic [SW-1:0] m_ctrl_wstrb;
  logic          m_ctrl_bvalid, m_ctrl_bready;
  logic [1:0]    m_ctrl_bresp;
  logic          m_ctrl_arvalid, m_ctrl_arready;
  logic [AW-1:0] m_ctrl_araddr;
  logic [2:0]    m_ctrl_arprot;
  logic          m_ctrl_rvalid, m_ctrl_rready;
  logic [DW-1:0] m_ctrl_rdata;
  logic [1:0]    m_ctrl_rresp;

  axil_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_ctrl_awvalid(m_ctrl_awvalid), .m_ctrl_awready(m_ctrl_awready),
    .m_ctrl_awaddr(m_ctrl_awaddr), .m_ctrl_awprot(m_ctrl_awprot),
    .m_ctrl_wvalid(m_ctrl_wvalid), .m_ctrl_wready(m_ctrl_wready),
    .m_ctrl_wdata(m_ctrl_wdata), .m_ctrl_wstrb(m_ctrl_wstrb),
    .m_ctrl_bvalid(m_ctrl_bvalid), .m_ctrl_bready(m_ctrl_bready),
    .m_ctrl_bresp(m_ctrl_bresp),
    .m_ctrl_arvalid(m_ctrl_arvalid), .m_ctrl_arready(m_ctrl_arready),
    .m_ctrl_araddr(m_ctrl_araddr), .m_ctrl_arprot(m_ctrl_arprot),
    .m_ctrl_rvalid(m_ctrl_rvalid), .m_ctrl_rready(m_ctrl_rready),
    .m_ctrl_rdata(m_ctrl_rdata), .m_ctrl_rresp(m_ctrl_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // number of rising edges so far
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    int          lat;   // edges from acceptance to rsp_valid, -1 = unchecked
    int          acc;
  } exp_t;

  exp_t sb[$];

  // target knobs
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0, rsp_hold = 0;
  logic [1:0]  t_bresp = 2'b00, t_rresp = 2'b00;
  logic [31:0] t_rdata = 32'h0;
  // current command, for checking the request beats
  logic [31:0] cur_addr = 0, cur_wdata = 0;
  logic [3:0]  cur_wstrb = 0;
  logic [2:0]  cur_prot = 0;
  // handshake counters
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  int last_hs = 0, last_acc = 0;

  // --------------------------------------------------------------------
  // AXI4-Lite target. Everything is decided at the falling edge; signals
  // stay put until the next rising edge, so valid && ready seen here is
  // the handshake that happens at that rising edge.
  // --------------------------------------------------------------------
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit b_pend, r_pend, aw_seen, w_seen;
    bit aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p;
    bit aw_v_p, w_v_p, ar_v_p;
    m_ctrl_awready = 0; m_ctrl_wready = 0; m_ctrl_arready = 0;
    m_ctrl_bvalid = 0; m_ctrl_bresp = 0; m_ctrl_rvalid = 0;
    m_ctrl_rdata = 0; m_ctrl_rresp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        b_pend = 0; r_pend = 0; aw_seen = 0; w_seen = 0;
        aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
        aw_v_p = 0; w_v_p = 0; ar_v_p = 0;
        m_ctrl_awready = 0; m_ctrl_wready = 0; m_ctrl_arready = 0;
        m_ctrl_bvalid = 0; m_ctrl_rvalid = 0;
        continue;
      end
      // valids drop right after their own handshake, never before it
      if (aw_hs_p) check("aw_drop", m_ctrl_awvalid, 0);
      else if (aw_v_p) check("aw_hold", m_ctrl_awvalid, 1);
      if (w_hs_p) check("w_drop", m_ctrl_wvalid, 0);
      else if (w_v_p) check("w_hold", m_ctrl_wvalid, 1);
      if (ar_hs_p) check("ar_drop", m_ctrl_arvalid, 0);
      else if (ar_v_p) check("ar_hold", m_ctrl_arvalid, 1);

      // B channel
      if (b_hs_p) m_ctrl_bvalid = 0;
      b_hs_p = 0;
      if (b_pend && !m_ctrl_bvalid) begin
        if (b_wait >= b_dly) begin m_ctrl_bvalid = 1; m_ctrl_bresp = t_bresp; end
        else b_wait++;
      end
      if (m_ctrl_bvalid && m_ctrl_bready) begin
        b_n++; b_pend = 0; b_wait = 0; b_hs_p = 1;
      end

      // R channel
      if (r_hs_p) m_ctrl_rvalid = 0;
      r_hs_p = 0;
      if (r_pend && !m_ctrl_rvalid) begin
        if (r_wait >= r_dly) begin
          m_ctrl_rvalid = 1; m_ctrl_rdata = t_rdata; m_ctrl_rresp = t_rresp;
        end else r_wait++;
      end
      if (m_ctrl_rvalid && m_ctrl_rready) begin
        r_n++; r_pend = 0; r_wait = 0; r_hs_p = 1;
      end

      // AW / W / AR
      aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0;
      m_ctrl_awready = m_ctrl_awvalid && (aw_wait >= aw_dly);
      if (m_ctrl_awvalid && !m_ctrl_awready) aw_wait++;
      if (m_ctrl_awvalid && m_ctrl_awready) begin
        aw_n++; aw_wait = 0; aw_hs_p = 1; aw_seen = 1;
        check("awaddr", m_ctrl_awaddr, cur_addr);
        check("awprot", m_ctrl_awprot, cur_prot);
      end
      m_ctrl_wready = m_ctrl_wvalid && (w_wait >= w_dly);
      if (m_ctrl_wvalid && !m_ctrl_wready) w_wait++;
      if (m_ctrl_wvalid && m_ctrl_wready) begin
        w_n++; w_wait = 0; w_hs_p = 1; w_seen = 1;
        check("wdata", m_ctrl_wdata, cur_wdata);
        check("wstrb", m_ctrl_wstrb, cur_wstrb);
      end
      if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
      m_ctrl_arready = m_ctrl_arvalid && (ar_wait >= ar_dly);
      if (m_ctrl_arvalid && !m_ctrl_arready) ar_wait++;
      if (m_ctrl_arvalid && m_ctrl_arready) begin
        ar_n++; ar_wait = 0; ar_hs_p = 1; r_pend = 1;
        check("araddr", m_ctrl_araddr, cur_addr);
        check("arprot", m_ctrl_arprot, cur_prot);
      end
      aw_v_p = m_ctrl_awvalid; w_v_p = m_ctrl_wvalid; ar_v_p = m_ctrl_arvalid;
    end
  end

  // --------------------------------------------------------------------
  // Response monitor: holds rsp_ready low rsp_hold cycles, checks field
  // stability while held, and compares against the scoreboard.
  // --------------------------------------------------------------------
  initial begin
    bit pend, hs_p;
    int hold_n, first;
    logic [35:0] held;
    exp_t e;
    pend = 0; hs_p = 0; hold_n = 0; first = 0; held = 0;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (reset) begin pend = 0; hs_p = 0; rsp_ready = 0; continue; end
      if (hs_p) begin rsp_ready = 0; hs_p = 0; pend = 0; end
      if (rsp_valid) begin
        if (!pend) begin
          pend = 1; hold_n = 0; first = cyc;
          held = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
        end else begin
          check("rsp_stable", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, held);
        end
        rsp_ready = (hold_n >= rsp_hold);
        hold_n++;
        if (rsp_ready) begin
          hs_p = 1;
          last_hs = cyc + 1;
          $display("[TB] rsp wr=%0d rdata=%h resp=%0d tmo=%0d", rsp_write, rsp_rdata,
                   rsp_resp, rsp_timeout);
          check("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_write", rsp_write, e.wr);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
            check("rsp_timeout", rsp_timeout, e.tmo);
            if (e.lat >= 0) check("rsp_latency", first - e.acc, e.lat);
          end
        end
      end
    end
  end

  // drive one command and push its expected response on acceptance
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input exp_t e);
    int n;
    @(negedge clk);
    cur_addr = addr; cur_wdata = wdata; cur_wstrb = strb; cur_prot = prot;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_prot = prot;
    cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", cmd_ready, 1);
    e.acc = cyc + 1;
    last_acc = cyc + 1;
    sb.push_back(e);
    $display("[TB] cmd wr=%0d addr=%h wdata=%h strb=%h prot=%0d at edge %0d",
             wr, addr, wdata, strb, prot, e.acc);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check("all_responded", sb.size(), 0);
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic wr, input logic [31:0] rd, input logic [1:0] resp,
                              input logic tmo, input int lat);
    exp_t e;
    e.wr = wr; e.rdata = rd; e.resp = resp; e.tmo = tmo; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  initial begin
    int b_aw, b_w, b_b, b_ar, b_r, first_hs, n;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; cmd_prot = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ctrl", {m_ctrl_awvalid, m_ctrl_wvalid, m_ctrl_arvalid, m_ctrl_bready,
                       m_ctrl_rready, rsp_valid, rsp_timeout, rsp_write, rsp_resp}, 0);
    check("rst_data", |{rsp_rdata, m_ctrl_awaddr, m_ctrl_awprot, m_ctrl_wdata,
                        m_ctrl_wstrb, m_ctrl_araddr, m_ctrl_arprot}, 0);
    reset = 0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // basic write, target always ready
    b_aw = aw_n; b_w = w_n; b_b = b_n;
    do_cmd(1, 32'h0, 32'h5555_5555, 4'h5, 3'd0, mk(1, 0, 2'b00, 0, 2));
    wait_done();
    check("wr_aw_beats", aw_n - b_aw, 1);
    check("wr_w_beats", w_n - b_w, 1);
    check("wr_b_beats", b_n - b_b, 1);

    // basic read
    t_rdata = 32'h0000_0155;
    b_ar = ar_n; b_r = r_n;
    do_cmd(0, 32'h0, 32'h0, 4'h0, 3'd0, mk(0, 32'h155, 2'b00, 0, 2));
    wait_done();
    check("rd_ar_beats", ar_n - b_ar, 1);
    check("rd_r_beats", r_n - b_r, 1);

    // skewed write channels: AW late, then W late
    for (int k = 0; k < 2; k++) begin
      aw_dly = (k == 0) ? 3 : 1;
      w_dly  = (k == 0) ? 1 : 3;
      b_aw = aw_n; b_w = w_n; b_b = b_n;
      do_cmd(1, 32'h10 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 4'hF, 3'd2,
             mk(1, 0, 2'b00, 0, -1));
      wait_done();
      check("skew_aw_beats", aw_n - b_aw, 1);
      check("skew_w_beats", w_n - b_w, 1);
      check("skew_b_beats", b_n - b_b, 1);
    end
    aw_dly = 0; w_dly = 0;

    // response backpressure, second command blocked until after rsp handshake
    rsp_hold = 5;
    t_rdata = 32'hDEAD_BEEF;
    do_cmd(1, 32'h20, 32'h1234_5678, 4'h3, 3'd1, mk(1, 0, 2'b00, 0, 2));
    do_cmd(0, 32'h24, 32'h0, 4'h0, 3'd5, mk(0, 32'hDEAD_BEEF, 2'b00, 0, 2));
    first_hs = last_hs;
    check("block_accept_edge", last_acc, first_hs + 1);
    wait_done();
    rsp_hold = 0;

    // error responses
    t_bresp = 2'b10;
    do_cmd(1, 32'h30, 32'hCAFE_F00D, 4'h8, 3'd0, mk(1, 0, 2'b10, 0, 2));
    wait_done();
    t_bresp = 2'b00;
    t_rresp = 2'b11; t_rdata = 32'h0BAD_0BAD;
    do_cmd(0, 32'h34, 32'h0, 4'h0, 3'd0, mk(0, 32'h0BAD_0BAD, 2'b11, 0, 2));
    wait_done();
    t_rresp = 2'b00;

    // delayed B/R within no-watchdog limits
    b_dly = 4; r_dly = 3; t_rdata = 32'h7777_0001;
    do_cmd(1, 32'h40, 32'h1111_2222, 4'hC, 3'd0, mk(1, 0, 2'b00, 0, 6));
    wait_done();
    do_cmd(0, 32'h44, 32'h0, 4'h0, 3'd0, mk(0, 32'h7777_0001, 2'b00, 0, 5));
    wait_done();
    b_dly = 0; r_dly = 0;

`ifdef AXIL_INIT_TIMEOUT_EN
    // watchdog: R withheld 20 cycles with TIMEOUT = 8
    r_dly = 20; t_rdata = 32'h5A5A_5A5A;
    b_r = r_n;
    do_cmd(0, 32'h50, 32'h0, 4'h0, 3'd0, mk(0, 32'h0, 2'b10, 1, -1));
    wait_done();
    n = 0;
    while (r_n == b_r && n < 100) begin
      check("drain_cmd_ready", cmd_ready, 0);
      check("drain_rready", m_ctrl_rready, 1);
      @(negedge clk);
      n++;
    end
    check("late_r_consumed", r_n - b_r, 1);
    @(negedge clk);
    check("post_drain_ready", cmd_ready, 1);
    r_dly = 0; t_rdata = 32'h0000_0042;
    do_cmd(0, 32'h54, 32'h0, 4'h0, 3'd0, mk(0, 32'h42, 2'b00, 0, 2));
    wait_done();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
